// File: rtl/pipe_skid_reg.sv
// ============================================================================
// Module      : pipe_skid_reg
// Description : Pipeline register with a valid/ready handshake and a
//               two-entry skid buffer (main + skid). Absorbs a downstream
//               stall without any combinational ready path back upstream.
//               Supports synchronous flush and optional stall statistics.
// Ports       : clock       - rising-edge clock
//               reset_n     - asynchronous active-low reset
//               flush       - synchronous flush, discards all held data
//               in_valid    - upstream presents in_data
//               in_ready    - block accepts in_data this cycle (registered)
//               in_data     - upstream payload, WIDTH bits
//               out_valid   - out_data holds a valid entry (registered)
//               out_ready   - downstream accepts out_data this cycle
//               out_data    - head entry (registered)
//               stats_clear - clears stall_count (PIPE_SKID_REG_STATS_EN only)
//               stall_count - saturating stall counter (PIPE_SKID_REG_STATS_EN only)
// Options     : define PIPE_SKID_REG_STATS_EN to add the stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_skid_reg #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_SKID_REG_STATS_EN
  ,
  input  logic             stats_clear,
  output logic [15:0]      stall_count
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             r_out_valid;
  logic             r_in_ready;

  logic w_in_fire;
  logic w_out_fire;

  assign w_in_fire  = in_valid  & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main;

  // Handshake flags are kept as their own registers, updated together with
  // the state, so neither output depends combinationally on any input.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= EMPTY;
      r_main      <= RESET_VALUE;
      r_skid      <= RESET_VALUE;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else if (flush) begin
      // Data registers are left untouched; only the occupancy is dropped.
      r_state     <= EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            r_main      <= in_data;
            r_state     <= HALF;
            r_out_valid <= 1'b1;
            r_in_ready  <= 1'b1;
          end
        end
        HALF: begin
          if (w_in_fire && w_out_fire) begin
            r_main <= in_data;
          end else if (w_in_fire) begin
            // Downstream stalled: park the new word in the skid entry.
            r_skid      <= in_data;
            r_state     <= FULL;
            r_in_ready  <= 1'b0;
          end else if (w_out_fire) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        FULL: begin
          // in_ready is low here, so only a drain can happen.
          if (w_out_fire) begin
            r_main      <= r_skid;
            r_state     <= HALF;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= EMPTY;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

`ifdef PIPE_SKID_REG_STATS_EN
  logic [15:0] r_stall_count;

  assign stall_count = r_stall_count;

  // Clear wins over increment; flush has no effect on the counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_count <= 16'h0000;
    end else if (stats_clear) begin
      r_stall_count <= 16'h0000;
    end else if (r_out_valid && !out_ready && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'h0001;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
`default_nettype none

module tb_pipe_skid_reg;

  localparam int          W  = 32;
  localparam logic [31:0] RV = 32'hDEAD_BEEF;

  logic          clock     = 1'b0;
  logic          reset_n   = 1'b0;
  logic          flush     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  in_data   = '0;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
`ifdef PIPE_SKID_REG_STATS_EN
  logic          stats_clear = 1'b0;
  logic [15:0]   stall_count;
`endif

  int            n_vec = 0;
  int            n_bad = 0;
  logic [W-1:0]  sb[$];

  always #5 clock = ~clock;

  pipe_skid_reg #(
    .WIDTH       (W),
    .RESET_VALUE (RV)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data)
`ifdef PIPE_SKID_REG_STATS_EN
    ,
    .stats_clear (stats_clear),
    .stall_count (stall_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus, account transfers in the scoreboard, then
  // check the DUT against the scoreboard occupancy one step after the edge.
  task automatic drive(input logic v, input logic [31:0] d, input logic ord, input logic fl);
    in_valid  = v;
    in_data   = d;
    out_ready = ord;
    flush     = fl;
    if (out_valid && ord && sb.size() > 0) begin
      check("delivered", out_data, sb.pop_front());
    end
    if (fl) sb.delete();
    else if (v && in_ready) sb.push_back(d);
    @(posedge clock);
    #1;
    check("out_valid", out_valid, sb.size() != 0);
    check("in_ready", in_ready, sb.size() < 2);
    if (sb.size() > 0) check("head", out_data, sb[0]);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_data", out_data, RV);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Streaming at full throughput
    drive(1'b1, 32'd100, 1'b1, 1'b0);
    check("stream_first", out_data, 32'd100);
    drive(1'b1, 32'd5,   1'b1, 1'b0);
    check("stream_second", out_data, 32'd5);
    drive(1'b1, 32'd44,  1'b1, 1'b0);
    check("stream_third", out_data, 32'd44);
    drive(1'b0, 32'd0,   1'b1, 1'b0);

    // Backpressure: 1 and 2 absorbed, 3 held off
    drive(1'b1, 32'd1, 1'b0, 1'b0);
    drive(1'b1, 32'd2, 1'b0, 1'b0);
    check("bp_full_in_ready", in_ready, 1'b0);
    drive(1'b1, 32'd3, 1'b0, 1'b0);
    check("bp_hold_in_ready", in_ready, 1'b0);
    check("bp_hold_head", out_data, 32'd1);
    drive(1'b1, 32'd3, 1'b1, 1'b0);
    check("bp_ready_back", in_ready, 1'b1);
    check("bp_head2", out_data, 32'd2);
    drive(1'b1, 32'd3, 1'b1, 1'b0);
    check("bp_head3", out_data, 32'd3);
    drive(1'b0, 32'd0, 1'b1, 1'b0);

    // Flush while FULL with a word offered
    drive(1'b1, 32'd7, 1'b0, 1'b0);
    drive(1'b1, 32'd8, 1'b0, 1'b0);
    drive(1'b1, 32'd9, 1'b0, 1'b1);
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_in_ready", in_ready, 1'b1);
    check("flush_data_kept", out_data, 32'd7);
    repeat (3) drive(1'b0, 32'd0, 1'b1, 1'b0);

    // Simultaneous in/out fire in HALF
    drive(1'b1, 32'd10, 1'b0, 1'b0);
    drive(1'b1, 32'd11, 1'b1, 1'b0);
    check("sim_out_valid", out_valid, 1'b1);
    check("sim_in_ready", in_ready, 1'b1);
    check("sim_out_data", out_data, 32'd11);
    drive(1'b0, 32'd0, 1'b1, 1'b0);

    // Asynchronous reset between edges while FULL
    drive(1'b1, 32'd20, 1'b0, 1'b0);
    drive(1'b1, 32'd21, 1'b0, 1'b0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_out_data", out_data, RV);
    check("arst_in_ready", in_ready, 1'b1);
    sb.delete();
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    drive(1'b1, 32'd33, 1'b1, 1'b0);
    drive(1'b0, 32'd0,  1'b1, 1'b0);

`ifdef PIPE_SKID_REG_STATS_EN
    stats_clear = 1'b1;
    drive(1'b1, 32'd30, 1'b0, 1'b0);
    stats_clear = 1'b0;
    check("stat_base", stall_count, 32'd0);
    repeat (5) drive(1'b0, 32'd0, 1'b0, 1'b0);
    check("stat_five", stall_count, 32'd5);
    stats_clear = 1'b1;
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    stats_clear = 1'b0;
    check("stat_clear", stall_count, 32'd0);
    repeat (65534) drive(1'b0, 32'd0, 1'b0, 1'b0);
    check("stat_fffe", stall_count, 32'h0000_FFFE);
    repeat (3) drive(1'b0, 32'd0, 1'b0, 1'b0);
    check("stat_sat", stall_count, 32'h0000_FFFF);
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    check("stat_hold", stall_count, 32'h0000_FFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
